dmem_bridge: RTL and testbench
==============================

Name: dmem_bridge

Overview:
- Data-memory access unit directly downstream of the pipeline's memory stage.
- Takes the M-stage address, write data and access type, and runs one transaction on a req/ack data bus with variable latency.
- Builds byte enables, aligns store data and sign- or zero-extends load data.
- Asserts stallM to freeze the pipeline until the access completes. Flags misaligned accesses without touching the bus.

Parameters:
- TIMEOUT, 255: max cycles in BUSY waiting for bus_ack before aborting; 0 disables the timeout.
- AW, 32: bus address width. The bus address is word-aligned, so the low 2 bits are forced to 0.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- memreqM  in  1  M-stage instruction is a load or store.
- memwriteM  in  1  1 = store, 0 = load.
- sizeM  in  2  access size: 0 byte, 1 half, 2 word.
- signedM  in  1  load sign-extends when 1.
- aluoutM  in  32  byte address.
- writedataM  in  32  store data, right-justified.
- readdataM  out  32  formatted load data; valid in DONE.
- stallM  out  1  freeze pipeline F..M.
- adelM  out  1  load address error (combinational).
- adesM  out  1  store address error (combinational).
- berrM  out  1  one-cycle pulse on bus timeout.
- bus_req  out  1  request; held until ack.
- bus_we  out  1  write strobe.
- bus_addr  out  AW  word address.
- bus_be  out  4  byte enables.
- bus_wdata  out  32  lane-aligned write data.
- bus_ack  in  1  slave completion, one cycle.
- bus_rdata  in  32  read data, valid with ack.

Behaviour:
- Misalignment rule: half access with addr[0]=1, word access with addr[1:0]!=0, or sizeM=3.
  - Sets adelM (load) or adesM (store) combinationally.
  - No bus access; stallM=0.
- States: IDLE, BUSY, DONE.
- IDLE:
  - On an aligned memreqM, latch addr/we/be/wdata/size/signed and go to BUSY.
  - stallM = memreqM & aligned in IDLE and in BUSY; stallM=0 in DONE.
- BUSY:
  - bus_req=1 with stable bus_addr/bus_we/bus_be/bus_wdata every cycle.
  - On bus_ack, capture formatted bus_rdata into readdataM (stores capture nothing) and go to DONE.
- DONE:
  - readdataM is held and stallM=0, so the pipeline advances this cycle.
  - Next state is IDLE unconditionally; a back-to-back memreqM starts in that IDLE cycle.
- Latency: minimum 2 stall cycles (request cycle, plus ack in the first BUSY cycle), then DONE.
- Byte enables:
  - sb: be = 1<<addr[1:0], wdata = byte replicated ×4.
  - sh: be = 4'b0011 (addr[1]=0) or 4'b1100, wdata = half replicated ×2.
  - sw: be = 4'b1111.
  - Loads: be = 4'b1111.
- Loads: select lane by addr[1:0], then sign- or zero-extend to 32 bits.
- Timeout:
  - Cycle counter cleared on entry to BUSY.
  - When it reaches TIMEOUT without ack: drop bus_req, set readdataM=0, pulse berrM for 1 cycle, go to DONE.
- bus_ack outside BUSY: ignored.
- Reset (async, any state):
  - state=IDLE, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, readdataM=0, berrM=0, counter=0.
  - stallM follows the IDLE equation.
  - An ack arriving after a reset mid-BUSY is ignored; the slave must share the reset.

Optional Feature:
- Macro DMEM_WBUF_EN.
- When defined:
  - A store seen in IDLE latches into a one-entry write buffer with stallM=0, and the FSM enters BUSY to drain it in the background.
  - Any memreqM arriving while BUSY/DONE drains stalls until the FSM is back in IDLE, which preserves load-after-store ordering.
  - Loads are unchanged.
  - A timeout on a buffered store still pulses berrM, imprecisely.
- When undefined: stores stall exactly like loads.

Decomposition:
- Shared package dmem_pkg holds:
  - size encodings SZ_BYTE=2'd0, SZ_HALF=2'd1, SZ_WORD=2'd2;
  - state encodings S_IDLE/S_BUSY/S_DONE;
  - a misalignment helper function.
- One combinational sub-module, dmem_lane_fmt: store alignment and be generation, plus load lane extraction and extension.
- The FSM, counter and registers stay in dmem_bridge.

Test Plan:
- lw at 0x100, ack after 3 BUSY cycles with rdata 0xDEADBEEF:
  - stallM high for 4 cycles, then DONE with readdataM=0xDEADBEEF;
  - bus_addr=0x100, be=1111.
- lb signed at 0x103, rdata 0x80FFFFFF: readdataM=0xFFFFFF80. lbu at the same address gives 0x00000080.
- sh at 0x102, writedataM=0x1234ABCD: bus_be=1100, bus_wdata=0xABCDABCD, bus_we=1.
- lw at 0x102: adelM=1, stallM=0, bus_req stays 0. sw at 0x101: adesM=1.
- TIMEOUT=4, no ack: bus_req drops after 4 BUSY cycles, berrM pulses once, readdataM=0, stallM released.
- rst low mid-BUSY: bus_req=0 immediately. After release, the next lw completes normally. With DMEM_WBUF_EN: sw then immediate lw gives stallM=0 on the sw, and the lw stalls until the write ack.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings and alignment helper for the data-memory bridge.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Size 3 is not a legal access and is treated as misaligned.
  function automatic logic isMisaligned(input logic [1:0] size, input logic [1:0] addrLo);
    case (size)
      SZ_BYTE: isMisaligned = 1'b0;
      SZ_HALF: isMisaligned = addrLo[0];
      SZ_WORD: isMisaligned = (addrLo != 2'b00);
      default: isMisaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Combinational lane formatting: store byte enables and data replication,
// load lane extraction with sign/zero extension.
module dmem_lane_fmt
  import dmem_pkg::*;
(
  input  logic [1:0]  stSize,
  input  logic [1:0]  stAddr,
  input  logic        stWrite,
  input  logic [31:0] stData,
  output logic [3:0]  stBe,
  output logic [31:0] stWdata,
  input  logic [1:0]  ldSize,
  input  logic [1:0]  ldAddr,
  input  logic        ldSigned,
  input  logic [31:0] ldRaw,
  output logic [31:0] ldData
);

  logic [31:0] shifted;
  logic [15:0] halfLane;

  always_comb begin
    stBe    = 4'b1111;
    stWdata = stData;
    if (stWrite) begin
      case (stSize)
        SZ_BYTE: begin
          stBe    = 4'b0001 << stAddr;
          stWdata = {4{stData[7:0]}};
        end
        SZ_HALF: begin
          stBe    = stAddr[1] ? 4'b1100 : 4'b0011;
          stWdata = {2{stData[15:0]}};
        end
        default: begin
          stBe    = 4'b1111;
          stWdata = stData;
        end
      endcase
    end
  end

  always_comb begin
    shifted  = ldRaw >> {ldAddr, 3'b000};
    halfLane = ldAddr[1] ? ldRaw[31:16] : ldRaw[15:0];
    case (ldSize)
      SZ_BYTE: ldData = {{24{ldSigned & shifted[7]}}, shifted[7:0]};
      SZ_HALF: ldData = {{16{ldSigned & halfLane[15]}}, halfLane};
      default: ldData = ldRaw;
    endcase
  end

endmodule

// File: rtl/dmem_bridge.sv
// M-stage data-memory bridge: one req/ack bus transaction per access, with stall,
// misalignment flags and bus timeout. Optional store buffer under DMEM_WBUF_EN.
module dmem_bridge
  import dmem_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int AW      = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memreqM,
  input  logic          memwriteM,
  input  logic [1:0]    sizeM,
  input  logic          signedM,
  input  logic [31:0]   aluoutM,
  input  logic [31:0]   writedataM,
  output logic [31:0]   readdataM,
  output logic          stallM,
  output logic          adelM,
  output logic          adesM,
  output logic          berrM,
  output logic          bus_req,
  output logic          bus_we,
  output logic [AW-1:0] bus_addr,
  output logic [3:0]    bus_be,
  output logic [31:0]   bus_wdata,
  input  logic          bus_ack,
  input  logic [31:0]   bus_rdata,
  output logic [1:0]    stateDbg
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

  state_t        state, nextState;
  logic [CW-1:0] cnt;
  logic [1:0]    latAddrLo, latSize;
  logic          latSigned;
  logic          misaligned, reqGo, timeoutHit;
  logic          idleStall, doneStall;
  logic [3:0]    fmtBe;
  logic [31:0]   fmtWdata, fmtRdata;

  assign misaligned = isMisaligned(sizeM, aluoutM[1:0]);
  assign reqGo      = memreqM & ~misaligned;
  assign adelM      = memreqM & ~memwriteM & misaligned;
  assign adesM      = memreqM & memwriteM & misaligned;
  assign timeoutHit = (TIMEOUT != 0) && (cnt == CW'(TIMEOUT - 1)) && !bus_ack;
  assign stateDbg   = state;

`ifdef DMEM_WBUF_EN
  // Stores retire immediately; anything arriving while a store drains waits for IDLE.
  assign idleStall = reqGo & ~memwriteM;
  assign doneStall = reqGo & bus_we;
`else
  assign idleStall = reqGo;
  assign doneStall = 1'b0;
`endif

  dmem_lane_fmt u_fmt (
    .stSize   (sizeM),
    .stAddr   (aluoutM[1:0]),
    .stWrite  (memwriteM),
    .stData   (writedataM),
    .stBe     (fmtBe),
    .stWdata  (fmtWdata),
    .ldSize   (latSize),
    .ldAddr   (latAddrLo),
    .ldSigned (latSigned),
    .ldRaw    (bus_rdata),
    .ldData   (fmtRdata)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= nextState;
  end

  always_comb begin
    nextState = state;
    case (state)
      S_IDLE:  if (reqGo) nextState = S_BUSY;
      S_BUSY:  if (bus_ack || timeoutHit) nextState = S_DONE;
      S_DONE:  nextState = S_IDLE;
      default: nextState = S_IDLE;
    endcase
  end

  always_comb begin
    bus_req = 1'b0;
    stallM  = 1'b0;
    case (state)
      S_IDLE: stallM = idleStall;
      S_BUSY: begin
        bus_req = 1'b1;
        stallM  = reqGo;
      end
      S_DONE:  stallM = doneStall;
      default: stallM = idleStall;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus_we    <= 1'b0;
      bus_be    <= 4'b0000;
      bus_addr  <= '0;
      bus_wdata <= '0;
      latAddrLo <= 2'b00;
      latSize   <= SZ_WORD;
      latSigned <= 1'b0;
      readdataM <= '0;
      berrM     <= 1'b0;
      cnt       <= '0;
    end else begin
      berrM <= 1'b0;
      cnt   <= (state == S_BUSY) ? cnt + 1'b1 : '0;
      if (state == S_IDLE && reqGo) begin
        bus_we    <= memwriteM;
        bus_be    <= fmtBe;
        bus_addr  <= AW'({aluoutM[31:2], 2'b00});
        bus_wdata <= fmtWdata;
        latAddrLo <= aluoutM[1:0];
        latSize   <= sizeM;
        latSigned <= signedM;
      end
      if (state == S_BUSY) begin
        if (bus_ack) begin
          if (!bus_we) readdataM <= fmtRdata;
        end else if (timeoutHit) begin
          readdataM <= '0;
          berrM     <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_bridge.sv
// Directed and randomized checks of dmem_bridge against an arithmetic reference model.
module tb_dmem_bridge;
  import dmem_pkg::*;

  localparam int TO = 4;
`ifdef DMEM_WBUF_EN
  localparam bit WBUF = 1'b1;
`else
  localparam bit WBUF = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        memreqM = 1'b0, memwriteM = 1'b0, signedM = 1'b0;
  logic [1:0]  sizeM = 2'd0;
  logic [31:0] aluoutM = '0, writedataM = '0;
  logic [31:0] readdataM;
  logic        stallM, adelM, adesM, berrM, bus_req, bus_we;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;
  logic [1:0]  stateDbg;

  int total = 0;
  int bad = 0;
  logic [31:0] exp_q[$];
  logic [31:0] lastRd = '0;

  dmem_bridge #(.TIMEOUT(TO), .AW(32)) dut (
    .clk(clk), .rst(rst), .memreqM(memreqM), .memwriteM(memwriteM), .sizeM(sizeM),
    .signedM(signedM), .aluoutM(aluoutM), .writedataM(writedataM), .readdataM(readdataM),
    .stallM(stallM), .adelM(adelM), .adesM(adesM), .berrM(berrM), .bus_req(bus_req),
    .bus_we(bus_we), .bus_addr(bus_addr), .bus_be(bus_be), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata), .stateDbg(stateDbg)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] ref_be(input logic we, input logic [1:0] sz, input logic [31:0] a);
    if (!we || sz == 2'd2) return 4'hF;
    if (sz == 2'd0) return 4'(1 << (a % 4));
    return ((a % 4) >= 2) ? 4'hC : 4'h3;
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [1:0] sz, input logic [31:0] d);
    if (sz == 2'd0) return 32'(d % 256) * 32'h0101_0101;
    if (sz == 2'd1) return 32'(d % 65536) * 32'h0001_0001;
    return d;
  endfunction

  function automatic logic [31:0] ref_load(input logic [1:0] sz, input logic sgn,
                                           input logic [31:0] a, input logic [31:0] r);
    longint unsigned m, v;
    if (sz == 2'd2) return r;
    m = (sz == 2'd0) ? 64'd256 : 64'd65536;
    v = (64'(r) >> (8 * (a % 4))) % m;
    if (sgn && v >= m / 2) v = v + (64'h1_0000_0000 - m);
    return v[31:0];
  endfunction

  // One aligned access; returns at the DONE-cycle negedge with the request still presented.
  task automatic do_access(input logic we, input logic [1:0] sz, input logic sgn,
                           input logic [31:0] a, input logic [31:0] wd, input int lat,
                           input logic [31:0] rd, input string tag);
    bit buffered = WBUF && we;
    int stalls = 0;
    logic [31:0] exp;
    @(negedge clk);
    memreqM = 1'b1; memwriteM = we; sizeM = sz; signedM = sgn; aluoutM = a; writedataM = wd;
    #1;
    check({tag, " req_stall"}, 32'(stallM), 32'(!buffered));
    check({tag, " req_idle_bus"}, 32'(bus_req), 32'd0);
    if (stallM) stalls++;
    if (!we) exp_q.push_back(ref_load(sz, sgn, a, rd));
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      if (buffered) memreqM = 1'b0;
      if (k == lat) begin bus_ack = 1'b1; bus_rdata = rd; end
      #1;
      check({tag, " bus_req"}, 32'(bus_req), 32'd1);
      check({tag, " bus_addr"}, bus_addr, a & ~32'd3);
      check({tag, " bus_we"}, 32'(bus_we), 32'(we));
      check({tag, " bus_be"}, 32'(bus_be), 32'(ref_be(we, sz, a)));
      if (we) check({tag, " bus_wdata"}, bus_wdata, ref_wdata(sz, wd));
      if (stallM) stalls++;
    end
    @(negedge clk);
    bus_ack = 1'b0; bus_rdata = $urandom;
    #1;
    check({tag, " done_stall"}, 32'(stallM), 32'd0);
    check({tag, " done_req"}, 32'(bus_req), 32'd0);
    check({tag, " done_berr"}, 32'(berrM), 32'd0);
    if (!we) begin
      exp = exp_q.pop_front();
      lastRd = exp;
    end
    check({tag, " readdata"}, readdataM, lastRd);
    check({tag, " stall_cycles"}, 32'(stalls), buffered ? 32'd0 : 32'(lat + 1));
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check("rst readdata", readdataM, 32'd0);
    check("rst bus_req", 32'(bus_req), 32'd0);
    check("rst bus_be", 32'(bus_be), 32'd0);
    check("rst bus_addr", bus_addr, 32'd0);
    check("rst bus_wdata", bus_wdata, 32'd0);
    check("rst berr", 32'(berrM), 32'd0);
    check("rst stall", 32'(stallM), 32'd0);
    check("rst state", 32'(stateDbg), 32'(S_IDLE));
    @(negedge clk);
    rst = 1'b1;

    do_access(1'b0, 2'd2, 1'b0, 32'h100, 32'h0, 3, 32'hDEAD_BEEF, "lw100");
    do_access(1'b0, 2'd0, 1'b1, 32'h103, 32'h0, 1, 32'h80FF_FFFF, "lb103");
    do_access(1'b0, 2'd0, 1'b0, 32'h103, 32'h0, 2, 32'h80FF_FFFF, "lbu103");
    do_access(1'b1, 2'd1, 1'b0, 32'h102, 32'h1234_ABCD, 1, 32'h0, "sh102");

    // Misaligned accesses never reach the bus
    @(negedge clk);
    memreqM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; aluoutM = 32'h102;
    #1;
    check("lw102 adel", 32'(adelM), 32'd1);
    check("lw102 ades", 32'(adesM), 32'd0);
    check("lw102 stall", 32'(stallM), 32'd0);
    @(negedge clk);
    memwriteM = 1'b1; aluoutM = 32'h101;
    #1;
    check("lw102 no_req", 32'(bus_req), 32'd0);
    check("sw101 ades", 32'(adesM), 32'd1);
    check("sw101 adel", 32'(adelM), 32'd0);
    check("sw101 stall", 32'(stallM), 32'd0);
    @(negedge clk);
    memwriteM = 1'b0; sizeM = 2'd3; aluoutM = 32'h100;
    #1;
    check("sz3 adel", 32'(adelM), 32'd1);
    check("sz3 stall", 32'(stallM), 32'd0);
    @(negedge clk);
    memreqM = 1'b0;
    #1;
    check("mis no_req", 32'(bus_req), 32'd0);
    check("mis state", 32'(stateDbg), 32'(S_IDLE));

    // Timeout with no ack
    @(negedge clk);
    memreqM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; signedM = 1'b0; aluoutM = 32'h200;
    #1;
    check("to req_stall", 32'(stallM), 32'd1);
    for (int k = 1; k <= TO; k++) begin
      @(negedge clk);
      #1;
      check("to busy_req", 32'(bus_req), 32'd1);
      check("to busy_stall", 32'(stallM), 32'd1);
    end
    @(negedge clk);
    #1;
    check("to req_drop", 32'(bus_req), 32'd0);
    check("to berr", 32'(berrM), 32'd1);
    check("to readdata", readdataM, 32'd0);
    check("to stall", 32'(stallM), 32'd0);
    lastRd = '0;
    @(negedge clk);
    memreqM = 1'b0;
    #1;
    check("to berr_pulse", 32'(berrM), 32'd0);
    check("to idle_req", 32'(bus_req), 32'd0);

    // Give readdataM a nonzero value, then reset mid-BUSY
    do_access(1'b0, 2'd2, 1'b0, 32'h2F0, 32'h0, 1, 32'h1357_9BDF, "lw2f0");
    @(negedge clk);
    memreqM = 1'b1; memwriteM = 1'b0; sizeM = 2'd2; aluoutM = 32'h300;
    @(negedge clk);
    #1;
    check("rb busy_req", 32'(bus_req), 32'd1);
    rst = 1'b0;
    #1;
    check("rb req_drop", 32'(bus_req), 32'd0);
    check("rb stall_idle_eq", 32'(stallM), 32'd1);
    check("rb readdata", readdataM, 32'd0);
    check("rb bus_be", 32'(bus_be), 32'd0);
    lastRd = '0;
    @(negedge clk);
    rst = 1'b1; memreqM = 1'b0; bus_ack = 1'b1; bus_rdata = 32'hFFFF_0000;
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("rb stray_ack_req", 32'(bus_req), 32'd0);
    check("rb stray_ack_data", readdataM, 32'd0);
    check("rb stray_ack_state", 32'(stateDbg), 32'(S_IDLE));
    do_access(1'b0, 2'd2, 1'b0, 32'h304, 32'h0, 2, 32'h0BAD_F00D, "lw304");

`ifdef DMEM_WBUF_EN
    // Buffered store followed immediately by a load
    @(negedge clk);
    memreqM = 1'b1; memwriteM = 1'b1; sizeM = 2'd2; aluoutM = 32'h400; writedataM = 32'hCAFE_0001;
    #1;
    check("wb sw_stall", 32'(stallM), 32'd0);
    @(negedge clk);
    memwriteM = 1'b0; aluoutM = 32'h404;
    #1;
    check("wb lw_busy_stall", 32'(stallM), 32'd1);
    check("wb drain_we", 32'(bus_we), 32'd1);
    @(negedge clk);
    bus_ack = 1'b1;
    #1;
    check("wb lw_ack_stall", 32'(stallM), 32'd1);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("wb lw_done_stall", 32'(stallM), 32'd1);
    @(negedge clk);
    #1;
    check("wb lw_idle_stall", 32'(stallM), 32'd1);
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'h7777_1234;
    #1;
    check("wb lw_addr", bus_addr, 32'h404);
    check("wb lw_we", 32'(bus_we), 32'd0);
    @(negedge clk);
    bus_ack = 1'b0;
    #1;
    check("wb lw_done", 32'(stallM), 32'd0);
    check("wb lw_data", readdataM, 32'h7777_1234);
    lastRd = 32'h7777_1234;
    @(negedge clk);
    memreqM = 1'b0;
`endif

    // Randomized aligned traffic
    for (int n = 0; n < 40; n++) begin
      logic        we;
      logic [1:0]  sz;
      logic [31:0] a;
      we = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 2));
      a  = $urandom & 32'hFFFF_FFFC;
      if (sz == 2'd0) a = a + 32'($urandom_range(0, 3));
      if (sz == 2'd1) a = a + 32'(2 * $urandom_range(0, 1));
      do_access(we, sz, 1'($urandom_range(0, 1)), a, $urandom, $urandom_range(1, 3), $urandom, "rnd");
      if ($urandom_range(0, 1) == 1) begin
        @(negedge clk);
        memreqM = 1'b0;
      end
    end
    @(negedge clk);
    memreqM = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
